// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// default timing constants.
package uart_tx_arbiter_pkg;

    // FSM state encoding (kept as plain constants for legacy tool flows)
    typedef logic [2:0] state_t;

    localparam state_t StIdle     = 3'd0;
    localparam state_t StLaunch   = 3'd1;
    localparam state_t StWaitAck  = 3'd2;
    localparam state_t StWaitDone = 3'd3;
    localparam state_t StGap      = 3'd4;

    // Idle cycles after tx_busy falls before the next launch (stop-bit guard)
    localparam int unsigned DefaultGapCycles  = 2;
    // Cycles allowed for tx_busy to rise after a launch
    localparam int unsigned DefaultAckTimeout = 4;

    // Width of the shared ack-timeout / gap counter
    localparam int unsigned CntW = 16;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin priority selector: grants the first asserted request at or
// after ptr, wrapping around the request vector.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    // Scan from ptr upward, wrapping, and keep the first hit
    always_comb begin
        logic [IDX_W-1:0] sel;
        sel       = '0;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sel = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (!any_grant && req[sel]) begin
                any_grant  = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte requesters. Grants are
// round-robin, one frame at a time, with a launch handshake timeout and an
// enforced idle gap after each frame.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned GAP_CYCLES  = DefaultGapCycles,
    parameter int unsigned ACK_TIMEOUT = DefaultAckTimeout
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       ctrl_busy,
    output logic                       err_timeout
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    state_t            state_q, state_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [IdxW-1:0]   grant_id_q, grant_id_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IdxW-1:0]    arb_idx;
    logic               arb_any;
    logic               grant_fire;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IdxW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    // Grant only from IDLE with the transmitter free; masked while reset is
    // held so no acceptance is signalled before the first live clock edge.
    always_comb begin
        grant_fire = (state_q == StIdle) && !tx_busy && arb_any && !reset;
    end

    // Next-state, counter and grant bookkeeping
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        case (state_q)
            StIdle: begin
                if (grant_fire) begin
                    tx_data_d  = req_data[8*arb_idx +: 8];
                    grant_id_d = arb_idx;
                    // Winner drops to lowest priority for the next round
                    if (arb_idx == IdxW'(NUM_REQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = arb_idx + IdxW'(1);
                    end
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                cnt_d   = '0;
                state_d = StWaitAck;
            end
            StWaitAck: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else if (cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    cnt_d   = '0;
                    state_d = StGap;
                end
            end
            StGap: begin
                // A zero-length gap still spends one cycle here
                if (GAP_CYCLES <= 1 || cnt_q == CntW'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Output decode from state plus the Mealy grant/timeout pulses
    always_comb begin
        req_ready   = grant_fire ? arb_grant : '0;
        tx_start    = (state_q == StLaunch);
        err_timeout = (state_q == StWaitAck) && !tx_busy &&
                      (cnt_q == CntW'(ACK_TIMEOUT - 1));
        ctrl_busy   = (state_q != StIdle);
        tx_data     = tx_data_q;
        grant_id    = grant_id_q;
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            tx_data_q  <= 8'h00;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random
// traffic, a behavioural UART transmitter, a serial-line decoder and a
// scoreboard fed by a timing-level reference model.
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int IW   = $clog2(N);
    localparam int GAP  = 2;
    localparam int ACK  = 4;
    localparam int BIT  = 2;
    localparam int GAPM = (GAP < 1) ? 1 : GAP;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;
    logic [IW-1:0] grant_id;
    logic          ctrl_busy;
    logic          err_timeout;

    logic uart_busy = 1'b0;
    logic ext_busy = 1'b0;
    logic ser_line = 1'b1;
    bit   uart_active = 1'b0;
    bit   uart_stuck = 1'b0;

    assign tx_busy = uart_busy | ext_busy;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (N),
        .GAP_CYCLES  (GAP),
        .ACK_TIMEOUT (ACK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .ctrl_busy   (ctrl_busy),
        .err_timeout (err_timeout)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    // ---------------- reference model + scoreboard monitor ----------------
    typedef struct {
        logic [IW-1:0] id;
        logic [7:0]    data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ser_q[$];
    logic [N-1:0] acc_seen = '0;

    int cyc = 0;
    int mptr = 0;
    bit in_flight = 0;
    int ph = 0;          // 1: launch due, 2: awaiting busy, 3: awaiting busy fall
    int free_at = 0;
    int launch_cyc = 0;

    always @(negedge clk) begin
        logic [N-1:0] er;
        int gi;
        bit es, ee, ecb;
        exp_t e;
        cyc++;
        acc_seen = req_ready;
        if (reset) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_tx_start", tx_start, 0);
            chk("rst_err_timeout", err_timeout, 0);
            chk("rst_tx_data", tx_data, 0);
            chk("rst_grant_id", grant_id, 0);
            chk("rst_ctrl_busy", ctrl_busy, 0);
            mptr = 0;
            in_flight = 0;
            ph = 0;
            free_at = cyc + 1;
            exp_q.delete();
        end else begin
            er = '0;
            gi = -1;
            if (!in_flight && cyc >= free_at && !tx_busy) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (mptr + k) % N;
                    if (gi < 0 && req_valid[j]) gi = j;
                end
            end
            if (gi >= 0) er[gi] = 1'b1;
            es  = in_flight && ph == 1;
            ee  = in_flight && ph == 2 && !tx_busy && (cyc == launch_cyc + ACK);
            ecb = in_flight || (cyc < free_at);
            if (er != 0 || req_ready != 0) chk("req_ready", req_ready, er);
            if (es || tx_start) chk("tx_start", tx_start, es);
            if (ee || err_timeout) chk("err_timeout", err_timeout, ee);
            chk("ctrl_busy", ctrl_busy, ecb);
            if (tx_start) begin
                if (exp_q.size() == 0) begin
                    chk("launch_without_grant", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_data", tx_data, e.data);
                    chk("grant_id", grant_id, e.id);
                end
            end
            if (gi >= 0) begin
                e.id = IW'(gi);
                e.data = req_data[8*gi +: 8];
                exp_q.push_back(e);
                if (!uart_stuck) ser_q.push_back(e.data);
                mptr = (gi + 1) % N;
                in_flight = 1;
                ph = 1;
            end else if (in_flight) begin
                case (ph)
                    1: begin
                        ph = 2;
                        launch_cyc = cyc;
                    end
                    2: begin
                        if (tx_busy) ph = 3;
                        else if (cyc == launch_cyc + ACK) begin
                            in_flight = 0;
                            free_at = cyc + GAPM + 1;
                        end
                    end
                    3: begin
                        if (!tx_busy) begin
                            in_flight = 0;
                            free_at = cyc + GAPM + 1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- behavioural UART transmitter ----------------
    initial begin
        logic [9:0] fb;
        int lat;
        forever begin
            @(negedge clk);
            if (tx_start && !reset && !uart_stuck) begin
                fb = {1'b1, tx_data, 1'b0};
                lat = $urandom_range(1, 3);
                uart_active = 1;
                repeat (lat) @(posedge clk);
                #1 uart_busy = 1'b1;
                for (int j = 0; j < 10; j++) begin
                    ser_line = fb[j];
                    repeat (BIT) begin
                        @(posedge clk);
                        #1;
                    end
                end
                ser_line = 1'b1;
                uart_busy = 1'b0;
                uart_active = 0;
            end
        end
    end

    // ---------------- serial line decoder ----------------
    bit         rx_active = 0;
    int         rx_t = 0;
    int         high_run = 0;
    int         frames_rx = 0;
    bit         saw_reset = 1;
    logic [7:0] rx_byte = '0;

    always @(negedge clk) begin
        int k;
        if (reset) saw_reset = 1;
        if (!rx_active) begin
            if (!ser_line) begin
                if (frames_rx > 0 && !saw_reset)
                    chk("inter_frame_high", high_run >= BIT + GAP + 2, 1);
                rx_active = 1;
                rx_t = 0;
                high_run = 0;
                saw_reset = 0;
            end else begin
                high_run++;
            end
        end else begin
            rx_t++;
            if (rx_t % BIT == 0) begin
                k = rx_t / BIT;
                if (k <= 8) begin
                    rx_byte[k-1] = ser_line;
                end else begin
                    chk("stop_bit", ser_line, 1);
                    if (ser_q.size() == 0) chk("frame_unexpected", 1, 0);
                    else chk("serial_byte", rx_byte, ser_q.pop_front());
                    rx_active = 0;
                    frames_rx++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc_seen;
    endtask

    task automatic raise(input int i, input logic [7:0] d);
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = d;
    endtask

    task automatic wait_accept(input int max, input string name);
        bit ok = 0;
        for (int t = 0; t < max && !ok; t++) begin
            step();
            if (acc_seen != 0) ok = 1;
        end
        if (!ok) chk(name, 0, 1);
    endtask

    task automatic wait_idle(input int max, input string name);
        bit ok = 0;
        for (int t = 0; t < max && !ok; t++) begin
            step();
            if (req_valid == 0 && !ctrl_busy && !tx_busy && !uart_active) ok = 1;
        end
        chk(name, ok, 1);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    initial begin
        int order[5];
        int ng;
        int base;
        bit got;
        order = '{0, 1, 2, 3, 0};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Single byte from requester 0
        raise(0, 8'hA5);
        wait_accept(10, "t1_accept_timeout");
        chk("t1_ready", acc_seen, 4'b0001);
        chk("t1_tx_start", tx_start, 1);
        chk("t1_tx_data", tx_data, 8'hA5);
        chk("t1_grant_id", grant_id, 0);
        wait_idle(200, "t1_idle");

        // All four requesting continuously from a fresh pointer
        do_reset(2);
        for (int i = 0; i < N; i++) raise(i, 8'h10 + 8'(i));
        ng = 0;
        for (int t = 0; t < 400 && ng < 5; t++) begin
            step();
            if (acc_seen != 0) begin
                for (int i = 0; i < N; i++) begin
                    if (acc_seen[i]) begin
                        chk("t2_order", i, order[ng]);
                        if (ng < 4) raise(i, 8'h10 + 8'(i));
                    end
                end
                ng++;
            end
        end
        chk("t2_grant_count", ng, 5);
        wait_idle(400, "t2_idle");

        // External busy in IDLE blocks the grant
        ext_busy = 1'b1;
        raise(3, 8'h3C);
        got = 0;
        for (int t = 0; t < 6; t++) begin
            step();
            if (acc_seen != 0) got = 1;
        end
        chk("t3_no_ready_while_busy", got, 0);
        ext_busy = 1'b0;
        wait_accept(10, "t3_accept_timeout");
        chk("t3_ready", acc_seen, 4'b1000);
        wait_idle(200, "t3_idle");

        // Stuck transmitter: timeout path
        uart_stuck = 1;
        raise(1, 8'h77);
        wait_accept(10, "t4_accept_timeout");
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            step();
            if (err_timeout) got = 1;
        end
        chk("t4_err_seen", got, 1);
        wait_idle(20, "t4_idle");
        uart_stuck = 0;

        // Reset asserted while the frame is on the wire
        raise(2, 8'hC3);
        wait_accept(10, "t5_accept_timeout");
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            step();
            if (tx_busy) got = 1;
        end
        chk("t5_busy_seen", got, 1);
        repeat (3) step();
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("t5_req_ready", req_ready, 0);
        chk("t5_tx_start", tx_start, 0);
        chk("t5_err_timeout", err_timeout, 0);
        chk("t5_tx_data", tx_data, 0);
        chk("t5_grant_id", grant_id, 0);
        chk("t5_ctrl_busy", ctrl_busy, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) raise(i, 8'h40 + 8'(i));
        @(posedge clk);
        #1 reset = 1'b0;
        wait_accept(80, "t5_post_reset_timeout");
        chk("t5_post_reset_winner", acc_seen, 4'b0001);
        wait_idle(400, "t5_idle");

        // End-to-end serial frames: 55, FF, 00 from requesters 2, 2, 1
        base = frames_rx;
        raise(2, 8'h55);
        wait_accept(10, "t6_a_timeout");
        chk("t6_a_ready", acc_seen, 4'b0100);
        raise(2, 8'hFF);
        wait_accept(80, "t6_b_timeout");
        chk("t6_b_ready", acc_seen, 4'b0100);
        raise(1, 8'h00);
        wait_accept(80, "t6_c_timeout");
        chk("t6_c_ready", acc_seen, 4'b0010);
        wait_idle(200, "t6_idle");
        chk("t6_frames", frames_rx - base, 3);

        // Random traffic
        for (int t = 0; t < 2500; t++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 7) == 0)
                    raise(i, 8'($urandom));
            end
        end
        wait_idle(800, "rand_drain");
        repeat (4) step();
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("serial_queue_empty", ser_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter GAP_CYCLES, default 2, idle cycles enforced after tx_busy falls before the next launch (stop-bit guard).
REQ-003 Parameter ACK_TIMEOUT, default 4, cycles allowed for tx_busy to rise after a launch.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester byte-pending flag; held until accepted.
REQ-007 req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 req_ready  output  NUM_REQ  one-hot, one-cycle pulse marking acceptance of requester i's byte.
REQ-009 tx_start  output  1  one-cycle launch pulse to the transmitter.
REQ-010 tx_data  output  8  byte to the transmitter; stable from launch until return to IDLE.
REQ-011 tx_busy  input  1  transmitter busy status.
REQ-012 grant_id  output  clog2(NUM_REQ)  index of the requester owning the current frame.
REQ-013 ctrl_busy  output  1  high in every state except IDLE.
REQ-014 err_timeout  output  1  one-cycle pulse when tx_busy fails to rise within ACK_TIMEOUT.

Function
REQ-015 FSM states: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, GAP.
REQ-016 IDLE: when tx_busy=0 and any req_valid=1, grant the first set bit at or after rr_ptr (wrapping); pulse req_ready[grant], latch req_data into tx_data, set grant_id, go to LAUNCH.
REQ-017 IDLE with tx_busy=1: no grant, remain in IDLE.
REQ-018 LAUNCH: tx_start=1 for exactly this cycle; go to WAIT_ACK; start timeout counter at 0.
REQ-019 WAIT_ACK: tx_busy=1 -> WAIT_DONE; counter reaches ACK_TIMEOUT-1 with tx_busy=0 -> pulse err_timeout, go to GAP.
REQ-020 WAIT_DONE: tx_busy falling to 0 -> GAP with gap counter at 0.
REQ-021 GAP: stay GAP_CYCLES cycles, then IDLE; GAP_CYCLES=0 makes GAP a single pass-through cycle.
REQ-022 rr_ptr updates to (grant+1) mod NUM_REQ on the grant cycle; the granted requester has lowest priority next round.
REQ-023 Launch-to-launch minimum is 4+GAP_CYCLES cycles plus frame time; back-to-back grants never overlap a frame.
REQ-024 req_valid changes outside IDLE are ignored; data is sampled only on the grant cycle.
REQ-025 Single-requester traffic: same requester may win consecutive rounds.
REQ-026 req_ready, tx_start, err_timeout never assert simultaneously with each other except req_ready in IDLE alone.

Reset
REQ-027 Reset (any cycle, including mid-frame) forces state IDLE, rr_ptr=0, counters=0, tx_start=0, req_ready=0, err_timeout=0, tx_data=8'h00, grant_id=0, ctrl_busy=0.
REQ-028 First grant after reset release occurs no earlier than the first rising edge with reset low.

Structure
REQ-029 Shared package holds the FSM state enum and default GAP_CYCLES/ACK_TIMEOUT constants.
REQ-030 Round-robin priority selection is a sub-module rr_arbiter (request vector, pointer in; one-hot grant, index, any-grant out).

Verification
REQ-031 Single byte: req_valid=4'b0001, data 8'hA5 -> req_ready[0] pulse, tx_start one cycle later, tx_data=8'hA5, grant_id=0.
REQ-032 All four requesting 8'h10..8'h13 continuously -> grant order 0,1,2,3,0; each tx_start separated by frame end plus 2 gap cycles.
REQ-033 Stuck transmitter (tx_busy held 0) -> err_timeout pulse 4 cycles after tx_start, FSM back to IDLE after gap.
REQ-034 tx_busy=1 externally in IDLE with req_valid=4'b1000 -> no req_ready until tx_busy=0.
REQ-035 Reset asserted during WAIT_DONE -> all outputs at reset values same cycle; rr_ptr=0, requester 0 wins next.
REQ-036 End-to-end with uart_tx model: three bytes 8'h55, 8'hFF, 8'h00 from requesters 2,2,1 -> serial line shows three complete frames, stop bit high at least 2 cycles between frames.
